// File: rtl/dmem_responder.sv
// Data-memory responder for a CPU load/store port, with a DONE_ADDR mailbox (Done/DoneData).
// Define DMEM_WAIT_EN to get a wait-state FSM; by default every access completes in zero wait states.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] DONE_ADDR   = 32'h64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemoryWrite,
  input  logic        MemoryRead,
  input  logic [31:0] DataAdder,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        Done,
  output logic [31:0] DoneData
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

  logic [31:0] mem [DEPTH];
  logic        done_q;
  logic [31:0] done_data_q;

  assign Done     = done_q;
  assign DoneData = done_data_q;

  function automatic logic in_range(input logic [31:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

`ifdef DMEM_WAIT_EN

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        wr_q, wr_d, rd_q, rd_d;
  // Access that completes on this edge, either straight from the bus or from the latches.
  logic        commit, c_wr, c_rd;
  logic [31:0] c_addr, c_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    c_wr    = wr_q;
    c_rd    = rd_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (MemoryWrite || MemoryRead) begin
          addr_d  = DataAdder;
          wdata_d = WriteData;
          wr_d    = MemoryWrite;
          rd_d    = MemoryRead;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
            c_wr    = MemoryWrite;
            c_rd    = MemoryRead;
            c_addr  = DataAdder;
            c_wdata = WriteData;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (commit) begin
      rdata_d = (c_rd && !c_wr && in_range(c_addr)) ? mem[word_idx(c_addr)] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      if (commit && c_wr && (c_addr == DONE_ADDR)) begin
        done_q      <= 1'b1;
        done_data_q <= c_wdata;
      end
    end
  end

  // RAM is not reset; the reset gate drops any write that would land while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_wr && in_range(c_addr)) begin
      mem[word_idx(c_addr)] <= c_wdata;
    end
  end

  always_comb begin
    MemReady = (state_q == StResp);
    ReadData = MemReady ? rdata_q : '0;
  end

`else

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q      <= 1'b0;
      done_data_q <= '0;
    end else if (MemoryWrite && (DataAdder == DONE_ADDR)) begin
      done_q      <= 1'b1;
      done_data_q <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && MemoryWrite && in_range(DataAdder)) begin
      mem[word_idx(DataAdder)] <= WriteData;
    end
  end

  always_comb begin
    MemReady = !reset;
    ReadData = '0;
    if (!reset && MemoryRead && !MemoryWrite && in_range(DataAdder)) begin
      ReadData = mem[word_idx(DataAdder)];
    end
  end

`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; follows DMEM_WAIT_EN to pick the expected timing.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemoryWrite, MemoryRead;
  logic [31:0] DataAdder, WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        Done;
  logic [31:0] DoneData;

  int n_cmp = 0;
  int n_err = 0;

  dmem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .MemoryWrite (MemoryWrite),
    .MemoryRead  (MemoryRead),
    .DataAdder   (DataAdder),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .MemReady    (MemReady),
    .Done        (Done),
    .DoneData    (DoneData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    MemoryWrite = w;
    MemoryRead  = r;
    DataAdder   = a;
    WriteData   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef DMEM_WAIT_EN
  // One access with WAIT_CYCLES = 2: ready only in the third cycle after the accepting edge.
  // Address/data are scrambled after acceptance to prove the block latched them.
  task automatic access(input string tag, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    drive(w, r, a, d);
    tick();
    check({tag, "_rdy_n1"}, 32'(MemReady), 32'd0);
    check({tag, "_rd_n1"}, ReadData, 32'd0);
    DataAdder = 32'h0;
    WriteData = 32'hBAD0_BAD0;
    tick();
    check({tag, "_rdy_n2"}, 32'(MemReady), 32'd0);
    tick();
    check({tag, "_rdy_n3"}, 32'(MemReady), 32'd1);
    check({tag, "_rdata"}, ReadData, exp_rd);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check({tag, "_rdy_after"}, 32'(MemReady), 32'd0);
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_ready", 32'(MemReady), 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_donedata", DoneData, 32'd0);
    tick();
    tick();
    reset = 1'b0;

`ifdef DMEM_WAIT_EN
    #1;
    check("idle_ready", 32'(MemReady), 32'd0);
    access("w60", 1'b1, 1'b0, 32'h60, 32'hDEAD_BEEF, 32'h0);
    check("done_low_after_w60", 32'(Done), 32'd0);
    access("w64", 1'b1, 1'b0, 32'h64, 32'd7, 32'h0);
    check("done_set", 32'(Done), 32'd1);
    check("donedata_7", DoneData, 32'd7);
    access("r64", 1'b0, 1'b1, 32'h64, 32'h0, 32'd7);
    access("r60", 1'b0, 1'b1, 32'h60, 32'h0, 32'hDEAD_BEEF);
    access("r63", 1'b0, 1'b1, 32'h63, 32'h0, 32'hDEAD_BEEF);
    access("w0", 1'b1, 1'b0, 32'h0, 32'h11, 32'h0);
    access("w400", 1'b1, 1'b0, 32'h400, 32'd5, 32'h0);
    access("r400", 1'b0, 1'b1, 32'h400, 32'h0, 32'h0);
    access("r0", 1'b0, 1'b1, 32'h0, 32'h0, 32'h11);
    access("rw10", 1'b1, 1'b1, 32'h10, 32'd3, 32'h0);
    access("r10", 1'b0, 1'b1, 32'h10, 32'h0, 32'd3);
    // Reset during WAIT: no ready, write of 9 lost, Done cleared, RAM kept.
    drive(1'b1, 1'b0, 32'h64, 32'd9);
    tick();
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(MemReady), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_donedata", DoneData, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("postrst_ready_a", 32'(MemReady), 32'd0);
    tick();
    check("postrst_ready_b", 32'(MemReady), 32'd0);
    check("postrst_done", 32'(Done), 32'd0);
    access("r64_postrst", 1'b0, 1'b1, 32'h64, 32'h0, 32'd7);
`else
    #1;
    check("ready_out_of_reset", 32'(MemReady), 32'd1);
    drive(1'b1, 1'b0, 32'h60, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("done_low_after_w60", 32'(Done), 32'd0);
    check("idle_rdata", ReadData, 32'd0);
    drive(1'b1, 1'b0, 32'h64, 32'd7);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("done_set", 32'(Done), 32'd1);
    check("donedata_7", DoneData, 32'd7);
    drive(1'b0, 1'b1, 32'h64, 32'h0);
    #1;
    check("r64", ReadData, 32'd7);
    drive(1'b0, 1'b1, 32'h60, 32'h0);
    #1;
    check("r60", ReadData, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 32'h63, 32'h0);
    #1;
    check("r63_lowbits_ignored", ReadData, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h0, 32'h11);
    tick();
    drive(1'b1, 1'b0, 32'h400, 32'd5);
    #1;
    check("w400_ready", 32'(MemReady), 32'd1);
    tick();
    drive(1'b0, 1'b1, 32'h400, 32'h0);
    #1;
    check("r400", ReadData, 32'h0);
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    #1;
    check("r0_unchanged", ReadData, 32'h11);
    drive(1'b1, 1'b1, 32'h10, 32'd3);
    #1;
    check("rw10_rdata_zero", ReadData, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    #1;
    check("r10", ReadData, 32'd3);
    drive(1'b1, 1'b0, 32'h64, 32'h22);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("done_sticky", 32'(Done), 32'd1);
    check("donedata_newest", DoneData, 32'h22);
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h64, 32'h0);
    #1;
    check("midrst_ready", 32'(MemReady), 32'd0);
    check("midrst_rdata", ReadData, 32'h0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_donedata", DoneData, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("postrst_ram_kept", ReadData, 32'h22);
    check("postrst_ready", 32'(MemReady), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: RAM depth in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states per access when DMEM_WAIT_EN is defined; legal range 0..15.
REQ-003 Parameter DONE_ADDR, default 32'h64: mailbox byte address.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 MemoryWrite  in  1  write request from CPU.
REQ-007 MemoryRead  in  1  read request from CPU.
REQ-008 DataAdder  in  32  byte address of the access.
REQ-009 WriteData  in  32  store data.
REQ-010 ReadData  out  32  load data.
REQ-011 MemReady  out  1  access-complete strobe.
REQ-012 Done  out  1  sticky flag; a write to DONE_ADDR has completed.
REQ-013 DoneData  out  32  data of the most recent completed write to DONE_ADDR.

Function
REQ-014 Word index = DataAdder[log2(DEPTH)+1:2]; DataAdder[1:0] ignored.
REQ-015 Address >= DEPTH*4: write dropped, read returns 0, MemReady still issued.
REQ-016 MemoryWrite and MemoryRead both high: treated as write; ReadData = 0 for that access.
REQ-017 Write commit: mem[index] <= WriteData on the completing edge only; never on an idle or wait cycle.
REQ-018 Write to DONE_ADDR on completion: Done <= 1, DoneData <= WriteData, and the RAM word is also written (index 25).
REQ-019 Repeated writes to DONE_ADDR: DoneData updates to the newest value; Done stays 1.
REQ-020 Requester holds MemoryWrite, MemoryRead, DataAdder and WriteData stable until the cycle MemReady = 1; the block latches them at request acceptance and ignores later changes.
REQ-021 With wait states: FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-022 IDLE: a request sampled at a rising edge latches address, data and type; goes to WAIT with counter = WAIT_CYCLES, or to RESP directly if WAIT_CYCLES = 0.
REQ-023 WAIT: counter decrements each cycle; at 1, goes to RESP.
REQ-024 RESP: lasts exactly one cycle with MemReady = 1; a write commits on the edge entering RESP; ReadData holds mem[index] (registered) during RESP.
REQ-025 RESP: returns to IDLE unconditionally; a request still asserted in the following IDLE cycle is a new access.
REQ-026 Access latency: WAIT_CYCLES + 1 cycles from the accepting edge to MemReady.
REQ-027 ReadData = 0 whenever MemReady = 0.

Reset
REQ-028 While reset is high: FSM = IDLE, counter = 0, MemReady = 0, ReadData = 0, Done = 0, DoneData = 0.
REQ-029 Reset asserted mid-access: the pending write is discarded and not committed; no MemReady is issued for it.
REQ-030 RAM contents are not cleared by reset.

Configuration
REQ-031 DMEM_WAIT_EN defined: FSM and wait-state behaviour per REQ-021..REQ-027.
REQ-032 DMEM_WAIT_EN undefined: zero-wait mode.
- No FSM and no counter; WAIT_CYCLES is ignored.
- MemReady = 1 whenever reset is low.
- ReadData = mem[index] combinationally while MemoryRead = 1 and MemoryWrite = 0; otherwise 0.
- Writes commit on every rising edge where MemoryWrite = 1.
- Done and DoneData update on that same edge.

Verification
REQ-033 Zero-wait (macro off): write 7 to 0x64, then read 0x64 -> ReadData = 7 in the same cycle; Done = 1; DoneData = 7.
REQ-034 WAIT_CYCLES = 2: read request at edge N -> MemReady = 1 only in cycle N+3, for one cycle, with correct ReadData; MemReady = 0 in N+1 and N+2.
REQ-035 Write 0xDEADBEEF to 0x60, then 7 to 0x64 -> Done rises only after the second access; reading 0x60 returns 0xDEADBEEF.
REQ-036 Write 5 to 0x400 (out of range) -> MemReady issued; a read of 0x400 returns 0; word 0 unchanged.
REQ-037 Start a write of 9 to 0x64, assert reset during WAIT -> no MemReady; after reset, Done = 0 and mem[25] is unchanged.
REQ-038 Read and write both asserted to 0x10 with data 3 -> mem[4] = 3; ReadData = 0 during MemReady.
